// File: rtl/food_spawner_pkg.sv
// Shared types and constants for the food spawner: FSM encoding, LFSR taps, grid defaults.
package food_spawner_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PROPOSE = 2'd1,
        SCAN    = 2'd2,
        COMMIT  = 2'd3
    } state_t;

    // Right-shift Galois form of x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int H_CELLS_DEF = 32;
    localparam int V_CELLS_DEF = 24;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/food_spawner_lfsr16.sv
// Free-running 16-bit Galois LFSR; a nonzero seed keeps it out of the all-zero lock-up state.
module lfsr16
    import food_spawner_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed,
    output logic [15:0] out
);

    always_ff @(posedge clk) begin
        if (rst) out <= seed;
        else     out <= lfsr_step(out);
    end

endmodule

// File: rtl/food_spawner.sv
// Food slot manager: detects eats and re-places food on free cells using LFSR candidates.
//   state   | meaning
//   IDLE    | waiting for a pending slot
//   PROPOSE | test LFSR candidate against grid, head and other food
//   SCAN    | walk body RAM looking for a collision with the candidate
//   COMMIT  | final head recheck, then write the slot
module food_spawner
    import food_spawner_pkg::*;
#(
    parameter int          H_CELLS   = H_CELLS_DEF,
    parameter int          V_CELLS   = V_CELLS_DEF,
    parameter int          X_W       = 5,
    parameter int          Y_W       = 5,
    parameter int          N_FOOD    = 2,
    parameter int          LEN_W     = 10,
    parameter int          MAX_TRIES = 64,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [X_W-1:0]          head_x,
    input  logic [Y_W-1:0]          head_y,
    input  logic [LEN_W-1:0]        length,
    output logic [LEN_W-1:0]        body_addr,
    input  logic [X_W-1:0]          body_x,
    input  logic [Y_W-1:0]          body_y,
    output logic [N_FOOD*X_W-1:0]   food_x,
    output logic [N_FOOD*Y_W-1:0]   food_y,
    output logic [N_FOOD-1:0]       food_valid,
    output logic                    eat_pulse,
    output logic [2:0]              eat_idx,
    output logic                    busy,
    output logic                    place_fail
);

    localparam int                TRY_W    = $clog2(MAX_TRIES + 1);
    localparam logic [TRY_W-1:0]  TRY_LAST = TRY_W'(MAX_TRIES - 1);
    localparam logic [X_W:0]      H_LIM    = (X_W+1)'(H_CELLS);
    localparam logic [Y_W:0]      V_LIM    = (Y_W+1)'(V_CELLS);

    state_t            state;
    logic [2:0]        target;
    logic [TRY_W-1:0]  tries;
    logic [X_W-1:0]    cand_x;
    logic [Y_W-1:0]    cand_y;
    logic [LEN_W-1:0]  scan_k;
    logic [N_FOOD-1:0] pending;
    logic [15:0]       lfsr;
    logic              lfsr_unused;

    lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (SEED),
        .out  (lfsr)
    );

    assign lfsr_unused = ^lfsr;
    assign busy = (state != IDLE);

    logic [X_W-1:0]    prop_x;
    logic [Y_W-1:0]    prop_y;
    logic              prop_slot_hit, prop_ok;
    logic [N_FOOD-1:0] eat_hit, tgt_mask, set_mask;
    logic [2:0]        eat_lo, pend_lo;
    logic              body_hit, cand_on_head, scan_done, commit_ok, reject, fail;
    logic [LEN_W:0]    scan_nxt;

    assign prop_x = lfsr[X_W-1:0];
    assign prop_y = lfsr[X_W+Y_W-1:X_W];

    always_comb begin
        prop_slot_hit = 1'b0;
        eat_hit       = '0;
        eat_lo        = '0;
        pend_lo       = '0;
        for (int i = 0; i < N_FOOD; i++) begin
            if (food_valid[i] && 3'(i) != target &&
                food_x[i*X_W +: X_W] == prop_x && food_y[i*Y_W +: Y_W] == prop_y)
                prop_slot_hit = 1'b1;
            eat_hit[i] = food_valid[i] &&
                         food_x[i*X_W +: X_W] == head_x && food_y[i*Y_W +: Y_W] == head_y;
        end
        for (int i = N_FOOD - 1; i >= 0; i--) begin
            if (eat_hit[i]) eat_lo  = 3'(i);
            if (pending[i]) pend_lo = 3'(i);
        end
    end

    assign prop_ok = ({1'b0, prop_x} < H_LIM) && ({1'b0, prop_y} < V_LIM) &&
                     !(prop_x == head_x && prop_y == head_y) && !prop_slot_hit;

    // Body data lags the address by one cycle, so the first SCAN cycle has nothing to compare
    assign body_hit     = (scan_k != '0) && body_x == cand_x && body_y == cand_y;
    assign scan_done    = (scan_k == length);
    assign scan_nxt     = {1'b0, scan_k} + 1'b1;
    assign cand_on_head = (cand_x == head_x) && (cand_y == head_y);
    assign commit_ok    = (state == COMMIT) && !cand_on_head;
    assign tgt_mask     = N_FOOD'(1) << target;
    assign set_mask     = commit_ok ? tgt_mask : '0;

    assign reject = (state == PROPOSE && !prop_ok) ||
                    (state == SCAN    && body_hit) ||
                    (state == COMMIT  && cand_on_head);
    assign fail   = reject && (tries == TRY_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            target     <= '0;
            tries      <= '0;
            cand_x     <= '0;
            cand_y     <= '0;
            scan_k     <= '0;
            body_addr  <= '0;
            eat_pulse  <= 1'b0;
            eat_idx    <= '0;
            place_fail <= 1'b0;
            food_x     <= '0;
            food_y     <= '0;
            food_x[X_W-1:0] <= X_W'(H_CELLS / 2);
            food_y[Y_W-1:0] <= Y_W'(V_CELLS / 2);
            food_valid <= N_FOOD'(1);
            pending    <= {N_FOOD{1'b1}} & ~N_FOOD'(1);
        end else begin
            eat_pulse  <= |eat_hit;
            eat_idx    <= eat_lo;
            place_fail <= 1'b0;
            food_valid <= (food_valid & ~eat_hit) | set_mask;
            pending    <= (pending | eat_hit) & ~set_mask;
            for (int i = 0; i < N_FOOD; i++) begin
                if (set_mask[i]) begin
                    food_x[i*X_W +: X_W] <= cand_x;
                    food_y[i*Y_W +: Y_W] <= cand_y;
                end
            end

            case (state)
                IDLE: begin
                    if (|pending) begin
                        target <= pend_lo;
                        tries  <= '0;
                        state  <= PROPOSE;
                    end
                end
                PROPOSE: begin
                    if (prop_ok) begin
                        cand_x    <= prop_x;
                        cand_y    <= prop_y;
                        scan_k    <= '0;
                        body_addr <= '0;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    if (body_hit) begin
                        state <= PROPOSE;
                    end else if (scan_done) begin
                        state <= COMMIT;
                    end else begin
                        scan_k <= scan_nxt[LEN_W-1:0];
                        if (scan_nxt < {1'b0, length})
                            body_addr <= scan_nxt[LEN_W-1:0];
                    end
                end
                COMMIT: begin
                    state <= cand_on_head ? PROPOSE : IDLE;
                end
                default: state <= IDLE;
            endcase

            // Retry budget exhausted: give up for now, slot stays pending and IDLE picks it up again
            if (reject) begin
                if (fail) begin
                    place_fail <= 1'b1;
                    tries      <= '0;
                    state      <= IDLE;
                end else begin
                    tries <= tries + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_food_spawner.sv
// Directed bench for food_spawner with a registered body RAM model (line or nearly-full grid).
module tb_food_spawner;

    localparam int X_W = 5, Y_W = 5, N_FOOD = 2, LEN_W = 10;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [X_W-1:0]        head_x;
    logic [Y_W-1:0]        head_y;
    logic [LEN_W-1:0]      length;
    logic [LEN_W-1:0]      body_addr;
    logic [X_W-1:0]        body_x;
    logic [Y_W-1:0]        body_y;
    logic [N_FOOD*X_W-1:0] food_x;
    logic [N_FOOD*Y_W-1:0] food_y;
    logic [N_FOOD-1:0]     food_valid;
    logic                  eat_pulse;
    logic [2:0]            eat_idx;
    logic                  busy;
    logic                  place_fail;

    int n_checks = 0;
    int n_errors = 0;
    bit full_mode = 1'b0;
    int free_idx  = 0;

    always #5 clk = ~clk;

    // SEED chosen so the first LFSR step is 16'h0085, i.e. first candidate (5,4)
    food_spawner #(
        .H_CELLS(32), .V_CELLS(24), .X_W(X_W), .Y_W(Y_W), .N_FOOD(N_FOOD),
        .LEN_W(LEN_W), .MAX_TRIES(64), .SEED(16'h010A)
    ) dut (
        .clk(clk), .rst(rst), .head_x(head_x), .head_y(head_y), .length(length),
        .body_addr(body_addr), .body_x(body_x), .body_y(body_y),
        .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
        .eat_pulse(eat_pulse), .eat_idx(eat_idx), .busy(busy), .place_fail(place_fail)
    );

    function automatic logic [9:0] body_cell(input int a);
        int c;
        if (full_mode) begin
            c = (a < free_idx) ? a : a + 1;
            return {5'(c / 32), 5'(c % 32)};
        end
        if (a < 5) return {5'd4, 5'(3 + a)};
        return {5'd31, 5'd31};
    endfunction

    always @(posedge clk) begin
        {body_y, body_x} <= body_cell(int'(body_addr));
    end

    function automatic int fx(input int i);
        return int'(food_x[i*X_W +: X_W]);
    endfunction
    function automatic int fy(input int i);
        return int'(food_y[i*Y_W +: Y_W]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int slot, input int budget, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            ok = food_valid[slot];
        end
        chk({tag, "_placed"}, 32'(ok), 1);
    endtask

    task automatic chk_place(input string tag, input int slot);
        int o = 1 - slot;
        chk({tag, "_y_range"},  32'(fy(slot) < 24), 1);
        chk({tag, "_not_head"}, 32'(fx(slot) == int'(head_x) && fy(slot) == int'(head_y)), 0);
        chk({tag, "_not_other"}, 32'(food_valid[o] && fx(slot) == fx(o) && fy(slot) == fy(o)), 0);
        chk({tag, "_not_body"}, 32'(!full_mode && fy(slot) == 4 && fx(slot) >= 3 && fx(slot) <= 7), 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, 32'(food_valid), 32'b01);
        chk({tag, "_s0x"}, 32'(fx(0)), 16);
        chk({tag, "_s0y"}, 32'(fy(0)), 12);
        chk({tag, "_s1x"}, 32'(fx(1)), 0);
        chk({tag, "_s1y"}, 32'(fy(1)), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_eat"}, 32'(eat_pulse), 0);
        chk({tag, "_fail"}, 32'(place_fail), 0);
        chk({tag, "_addr"}, 32'(body_addr), 0);
    endtask

    task automatic eat_slot(input int slot, input string tag);
        head_x = X_W'(fx(slot));
        head_y = Y_W'(fy(slot));
        tick();
        chk({tag, "_pulse"}, 32'(eat_pulse), 1);
        chk({tag, "_idx"}, 32'(eat_idx), 32'(slot));
        chk({tag, "_cleared"}, 32'(food_valid[slot]), 0);
    endtask

    initial begin
        bit ok;
        int fcx, fcy;
        rst = 1'b1; head_x = '0; head_y = '0; length = 10'd5;
        repeat (3) tick();
        chk_reset("rst");
        rst = 1'b0;

        // Initial slot1 placement; first candidate (5,4) lies on the body and must be rejected
        wait_valid(1, 600, "init1");
        chk_place("init1", 1);
        chk("init1_not_cand", 32'(fx(1) == 5 && fy(1) == 4), 0);
        chk("init1_slot0_kept", 32'(food_valid[0]), 1);
        chk("init1_idle", 32'(busy), 0);

        eat_slot(0, "eat0");
        head_x = '0; head_y = '0;
        tick();
        chk("eat0_one_cycle", 32'(eat_pulse), 0);
        wait_valid(0, 600, "replace0");
        chk_place("replace0", 0);

        // Two eats back to back: slot0 must come back before slot1
        eat_slot(0, "dbl0");
        eat_slot(1, "dbl1");
        head_x = '0; head_y = '0;
        chk("dbl_both_gone", 32'(food_valid), 0);
        ok = 1'b0;
        for (int i = 0; i < 600 && !ok; i++) begin
            tick();
            ok = (food_valid != '0);
        end
        chk("dbl_first_seen", 32'(ok), 1);
        chk("dbl_order", 32'(food_valid), 32'b01);
        ok = 1'b0;
        for (int i = 0; i < 600 && !ok; i++) begin
            tick();
            ok = (food_valid == 2'b11);
        end
        chk("dbl_both_valid", 32'(ok), 1);
        chk_place("dbl_s0", 0);
        chk_place("dbl_s1", 1);

        // Nearly full grid: only one free cell, avoiding slot1 and the head
        fcx = (fx(1) == 1 && fy(1) == 1) ? 2 : 1;
        fcy = 1;
        free_idx = fcy * 32 + fcx;
        full_mode = 1'b1;
        length = 10'd767;
        eat_slot(0, "full_eat");
        head_x = '0; head_y = '0;
        ok = 1'b0;
        for (int i = 0; i < 52000 && !ok; i++) begin
            tick();
            ok = place_fail || food_valid[0];
        end
        chk("full_resolved", 32'(ok), 1);
        if (food_valid[0]) begin
            chk("full_at_free_x", 32'(fx(0)), 32'(fcx));
            chk("full_at_free_y", 32'(fy(0)), 32'(fcy));
        end else if (place_fail) begin
            chk("fail_slot_invalid", 32'(food_valid[0]), 0);
            chk("fail_idle", 32'(busy), 0);
            tick();
            chk("fail_retry_busy", 32'(busy), 1);
            chk("fail_one_cycle", 32'(place_fail), 0);
        end

        // Abort a placement in SCAN with reset
        if (!busy) begin
            eat_slot(0, "abort_eat");
            head_x = '0; head_y = '0;
        end
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            tick();
            ok = (body_addr != '0);
        end
        chk("abort_in_scan", 32'(ok), 1);
        rst = 1'b1;
        tick();
        chk_reset("abort");
        full_mode = 1'b0;
        length = '0;
        tick();
        rst = 1'b0;

        // length 0 after reset: candidate (5,4) is free and gets committed
        wait_valid(1, 20, "len0");
        chk("len0_x", 32'(fx(1)), 5);
        chk("len0_y", 32'(fy(1)), 4);
        chk("len0_slot0", 32'(food_valid[0]), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
